// File: rtl/vdff_sample_pkg.sv
// Shared types and helpers for the vdff sample FIFO: FSM state encoding,
// timestamp width and the settle-counter width calculation.
package vdff_sample_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, PUSH} sample_state_t;

  localparam int TS_W = 16;

  // A settle of 0 or 1 still needs a one-bit counter.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/vdff_sample_buf.sv
// DEPTH-entry circular buffer with registered storage, push/pop arbitration
// and occupancy flags. A push into a full buffer is accepted when a pop
// happens in the same cycle.
module vdff_sample_buf #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [0:W-1]               wdata,
  input  logic                       pop_ready,
  output logic [0:W-1]               rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [0:W-1]  mem_q [DEPTH];
  logic [0:W-1]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  always_comb begin
    pop      = (count_q != '0) && pop_ready;
    push_ok  = push && ((count_q < CNT_FULL) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset too, so the head word reads 0 straight out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;
  assign full  = (count_q == CNT_FULL);

endmodule

// File: rtl/vdff_sample_fifo.sv
// Waits for the upstream vdff word to hold for SETTLE cycles, then queues it.
// Define VDFF_SAMPLE_TIMESTAMP_EN to store a 16-bit cycle stamp per entry (out_ts).
module vdff_sample_fifo
  import vdff_sample_pkg::*;
#(
  parameter int SIZE   = 5,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [0:SIZE-1]            in,
  output logic [0:SIZE-1]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
`ifdef VDFF_SAMPLE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]            out_ts
`endif
);

  localparam int CNT_W = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  // The SETTLE parameter hides the enum literal of the same name.
  localparam sample_state_t S_SETTLE = vdff_sample_pkg::SETTLE;

`ifdef VDFF_SAMPLE_TIMESTAMP_EN
  localparam int W = SIZE + TS_W;
`else
  localparam int W = SIZE;
`endif

  sample_state_t   state_q, state_d;
  logic [0:SIZE-1] last_q, last_d;
  logic [0:SIZE-1] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic            push_req;
  logic            push_ok;
  logic [0:W-1]    wr_word;
  logic [0:W-1]    rd_word;

  always_comb begin
    // NOTE: every _d gets a default first, so no path can infer a latch.
    state_d = state_q;
    last_d  = last_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in != last_q) begin
          cand_d = in;
          if (SETTLE == 0) begin
            state_d = PUSH;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
      end
      S_SETTLE: begin
        if (in != cand_q) begin
          cand_d = in;
          cnt_d  = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = PUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PUSH: begin
        // last tracks the settled word even when it is dropped.
        last_d  = cand_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_req   = (state_q == PUSH);
  assign overflow_d = overflow_q | (push_req & ~push_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q    <= state_d;
      last_q     <= last_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef VDFF_SAMPLE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_word = {cand_q, ts_q};
  assign out_ts  = rd_word[SIZE:W-1];
`else
  assign wr_word = cand_q;
`endif

  vdff_sample_buf #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .wdata     (wr_word),
    .pop_ready (out_ready),
    .rdata     (rd_word),
    .valid     (out_valid),
    .count     (count),
    .full      (full),
    .push_ok   (push_ok)
  );

  assign out_data = rd_word[0:SIZE-1];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vdff_sample_fifo.sv
// Self-checking bench for vdff_sample_fifo: directed scenarios with literal
// expectations plus randomized input/ready traffic against a queue-based model.
`timescale 1ns/1ps
module tb_vdff_sample_fifo;

  localparam int SIZE   = 5;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:SIZE-1] in_w = '0;
  logic            out_ready = 1'b0;
  logic [0:SIZE-1] out_data;
  logic            out_valid;
  logic [CW-1:0]   count;
  logic            full;
  logic            overflow;
`ifdef VDFF_SAMPLE_TIMESTAMP_EN
  logic [15:0]     out_ts;
`endif

  vdff_sample_fifo #(
    .SIZE   (SIZE),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_w),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
`ifdef VDFF_SAMPLE_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a settled word is pushed SETTLE+1 edges after the edge
  // that first sampled it, provided every sample in between matched it.
  typedef struct {
    logic [SIZE-1:0] data;
    logic [15:0]     ts;
  } entry_t;

  entry_t          mq[$];
  logic [SIZE-1:0] m_last, m_cand;
  bit              m_track, m_ovf, m_pop, m_ok;
  int              m_start, m_push_at, m_edge;
  logic [15:0]     m_ts;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_last    = '0;
      m_cand    = '0;
      m_track   = 1'b0;
      m_ovf     = 1'b0;
      m_push_at = -1;
      m_start   = 0;
      m_edge    = 0;
      m_ts      = '0;
    end else begin
      m_pop = (mq.size() != 0) && out_ready;
      m_ok  = (mq.size() < DEPTH) || m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push_at == m_edge) begin
        if (m_ok) mq.push_back('{data: m_cand, ts: m_ts});
        else      m_ovf = 1'b1;
        m_last    = m_cand;
        m_track   = 1'b0;
        m_push_at = -1;
      end else if (m_push_at < 0) begin
        if (!m_track) begin
          if (in_w != m_last) begin
            m_track = 1'b1;
            m_cand  = in_w;
            m_start = m_edge;
          end
        end else if (in_w != m_cand) begin
          m_cand  = in_w;
          m_start = m_edge;
        end
        if (m_track && (m_edge - m_start == SETTLE)) m_push_at = m_edge + 1;
      end
      m_edge++;
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", out_valid, mq.size() != 0);
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        check("data", out_data, mq[0].data);
`ifdef VDFF_SAMPLE_TIMESTAMP_EN
        check("ts", out_ts, mq[0].ts);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", out_data, 0);

`ifdef VDFF_SAMPLE_TIMESTAMP_EN
    // Change first sampled while the cycle counter reads 0x0010.
    hold(16);
    in_w = 5'b00001;
    hold(SETTLE + 2);
    check("ts_literal", out_ts, 16'h0011 + SETTLE);
    in_w = '0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
`endif

    // Basic capture with the consumer always ready.
    out_ready = 1'b1;
    in_w = 5'b10110;
    hold(3);
    check("basic_not_yet", out_valid, 0);
    tick();
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 5'b10110);
    check("basic_count", count, 1);
    tick();
    check("basic_drained", count, 0);

    // One-cycle glitch is filtered.
    out_ready = 1'b0;
    in_w = 5'b00011;
    tick();
    in_w = 5'b00111;
    hold(6);
    check("glitch_count", count, 1);
    check("glitch_data", out_data, 5'b00111);
    out_ready = 1'b1;
    tick();
    check("glitch_drained", count, 0);
    out_ready = 1'b0;

    // Overflow: five settled words into a four-entry FIFO.
    for (int v = 1; v <= 5; v++) begin
      in_w = SIZE'(v);
      hold(4);
      if (v == 4) begin
        check("ovf_full", full, 1);
        check("ovf_not_yet", overflow, 0);
      end
    end
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain", out_data, i);
      tick();
    end
    check("ovf_empty", count, 0);
    check("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    // Async reset while settling with three entries queued.
    for (int v = 6; v <= 8; v++) begin
      in_w = SIZE'(v);
      hold(4);
    end
    check("mid_count3", count, 3);
    in_w = 5'd9;
    hold(2);
    #2 rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_overflow", overflow, 0);
    in_w = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(6);
    check("post_rst_nopush", count, 0);

    // Full FIFO plus pop in the PUSH cycle: push accepted, pointers wrap.
    for (int v = 1; v <= 4; v++) begin
      in_w = SIZE'(v);
      hold(4);
    end
    check("fp_full", full, 1);
    in_w = 5'd10;
    hold(3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fp_count", count, 4);
    check("fp_overflow", overflow, 0);
    check("fp_head", out_data, 2);
    out_ready = 1'b1;
    check("fp_wrap0", out_data, 2);
    tick();
    check("fp_wrap1", out_data, 3);
    tick();
    check("fp_wrap2", out_data, 4);
    tick();
    check("fp_wrap3", out_data, 10);
    tick();
    check("fp_empty", count, 0);
    out_ready = 1'b0;

    // Away-and-back to the last pushed word is a new event.
    in_w = 5'd11;
    tick();
    in_w = 5'd10;
    hold(6);
    check("back_count", count, 1);
    check("back_data", out_data, 10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic: mostly a small alphabet so repeats and glitches occur.
    repeat (400) begin
      int dur;
      in_w = ($urandom_range(0, 3) == 0) ? SIZE'($urandom_range(0, 31))
                                         : SIZE'($urandom_range(0, 3));
      dur = $urandom_range(1, 5);
      repeat (dur) begin
        out_ready = ($urandom_range(0, 9) < 4);
        tick();
      end
    end
    out_ready = 1'b1;
    hold(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vdff_sample_fifo.md
Name: vdff_sample_fifo

Overview:
- Downstream consumer of the parameterized delayed-register stage (vdff).
- Watches the register's parallel output, waits for it to hold stable for SETTLE cycles, then pushes the settled word into a small FIFO.
- The FIFO drains to the next stage over a valid/ready handshake.
- Sits between the vdff instances and any checker or monitor logic under top.

Parameters:
- SIZE, 5, data width; bit order [0:SIZE-1], matching vdff.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SETTLE, 2, cycles the input must stay stable before capture; 0 allowed.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in  input  [0:SIZE-1]  output of the upstream vdff.
- out_data  output  [0:SIZE-1]  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  [$clog2(DEPTH+1)-1:0]  current occupancy.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a settled word was dropped.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; last, cand, settle counter, FIFO pointers = 0.
  - out_valid = 0, count = 0, full = 0, overflow = 0, out_data = 0.
- FSM states: IDLE, SETTLE, PUSH.
- IDLE:
  - If in != last: cand <= in.
  - If SETTLE == 0, go to PUSH; otherwise go to SETTLE with cnt <= 0.
- SETTLE:
  - If in != cand: cand <= in, cnt <= 0, stay in SETTLE (restart).
  - Else if cnt == SETTLE-1: go to PUSH.
  - Else: cnt <= cnt+1.
- PUSH (one cycle):
  - Always: last <= cand, then return to IDLE.
  - If space is available, write cand to the FIFO.
  - Otherwise drop cand and set overflow.
  - Changes on in during PUSH are seen by IDLE on the next edge.
- Latency:
  - Change first sampled at edge k, then stable: write occurs at edge k+SETTLE+1.
  - out_valid rises after that edge if the FIFO was empty.
  - With SETTLE = 0, the write occurs at edge k+1.
- Space rule: a push is accepted if count < DEPTH, or if a pop happens in the same cycle (out_valid && out_ready).
- Pop: on out_valid && out_ready, the read pointer advances. out_data is the registered head, with no combinational path from in.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- Pop while empty: ignored.
- overflow: cleared only by rst.
- Returning to the last-pushed value before settling: go to SETTLE with cand = the new value; the word is pushed again, because any settled change-away-and-back is a new event.
- Width rules:
  - cnt is $clog2(SETTLE+1) bits wide, minimum 1.
  - Pointers are $clog2(DEPTH) bits wide.

Optional Feature:
- Macro: VDFF_SAMPLE_TIMESTAMP_EN.
- When defined:
  - A free-running 16-bit cycle counter, cleared by rst, wraps 0xFFFF to 0.
  - The counter value at the PUSH cycle is stored alongside each entry.
  - It is presented on an extra output port out_ts [15:0], aligned with out_data.
- When undefined: no counter, no out_ts port, no extra storage.

Decomposition:
- Package vdff_sample_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETTLE, PUSH} sample_state_t;
  - localparam TS_W = 16;
  - a function computing the counter width for a given SETTLE.
- Sub-module vdff_sample_buf holds the DEPTH x SIZE storage, the pointers, count/full and the push/pop arbitration.
- The top module holds the FSM, the settle logic and overflow.

Test Plan (SIZE=5, DEPTH=4, SETTLE=2 unless stated):
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while in SETTLE with 3 entries queued.
  - Required: out_valid, count and overflow drop to 0 immediately, without waiting for a clock edge; after release, in=0 causes no push.
- Basic capture:
  - Stimulus: in 0 -> 5'b10110 held; out_ready=1.
  - Required: one push at edge k+3; out_data=10110 with out_valid for one cycle; count returns to 0.
- Glitch filtering:
  - Stimulus: in=00011 for 1 cycle, then 00111 held.
  - Required: exactly one entry, 00111; 00011 is never pushed.
- Overflow:
  - Stimulus: out_ready=0; five distinct settled values 1, 2, 3, 4, 5.
  - Required: full=1 after the 4th; overflow=1 after the 5th; draining yields 1, 2, 3, 4.
- Full with simultaneous pop:
  - Stimulus: FIFO full; a new value settles; out_ready=1 in the PUSH cycle.
  - Required: push accepted, count stays 4, overflow stays 0; pointer wrap is verified.
- Timestamp (macro on) plus SETTLE=0:
  - Stimulus: in changes at counter value 0x0010.
  - Required: entry pushed at the next edge with out_ts=0x0011.
